// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: funct codes, mul/div FSM states and datapath width.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Radix-2 iterative datapath shared by multiply and divide: one 2W-bit shift
// register, one W+1-bit add/subtract and the step counter.
module muldiv_iter_core #(
  parameter int unsigned W    = 32,
  parameter int unsigned ITER = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic           i_is_div,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_acc,
  output logic           o_last
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_b;
  logic [CW-1:0]  r_cnt;

  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [2*W-1:0] w_mul_next;
  logic [2*W-1:0] w_div_next;

  // Multiply: add multiplicand into the upper half when LSB is set, then shift right with carry.
  // Divide: shift left, trial-subtract divisor from the upper W+1 bits, restore on borrow.
  always_comb begin
    w_add      = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_b};
    w_sub      = r_acc[2*W-1:W-1] - {1'b0, r_b};
    w_mul_next = r_acc[0] ? {w_add, r_acc[W-1:1]}
                          : {1'b0, r_acc[2*W-1:W], r_acc[W-1:1]};
    w_div_next = w_sub[W] ? {r_acc[2*W-2:0], 1'b0}
                          : {w_sub[W-1:0], r_acc[W-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= {{W{1'b0}}, i_a};
      r_b   <= i_b;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= i_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CW'(ITER - 1));

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage MULT/MULTU/DIV/DIVU unit owning HI/LO; FSM, sign handling and
// result write-back around the shared iterative core.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  muldiv_state_t r_state, w_next;

  logic [XLEN-1:0]   r_hi, r_lo, r_dividend;
  logic              r_done, r_is_div, r_neg_res, r_neg_rem, r_div0;

  logic              w_is_md, w_is_div, w_signed, w_accept, w_step, w_last;
  logic [XLEN-1:0]   w_rs_abs, w_rt_abs;
  logic [2*XLEN-1:0] w_acc, w_prod;
  logic [XLEN-1:0]   w_quot, w_rem;

  always_comb begin
    w_is_md  = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    w_is_div = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    w_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    w_accept = (r_state == ST_IDLE) && op_valid && !flush && w_is_md;
    w_step   = (r_state == ST_CALC) && !flush;
    w_rs_abs = (w_signed && rs_val[XLEN-1]) ? -rs_val : rs_val;
    w_rt_abs = (w_signed && rt_val[XLEN-1]) ? -rt_val : rt_val;
  end

  muldiv_iter_core #(
    .W    (XLEN),
    .ITER (ITER)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_step   (w_step),
    .i_is_div (r_is_div),
    .i_a      (w_rs_abs),
    .i_b      (w_rt_abs),
    .o_acc    (w_acc),
    .o_last   (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_CALC;
      ST_CALC: begin
        if (flush)       w_next = ST_IDLE;
        else if (w_last) w_next = ST_FIX;
      end
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_prod = r_neg_res ? -w_acc : w_acc;
    w_quot = r_neg_res ? -w_acc[XLEN-1:0] : w_acc[XLEN-1:0];
    w_rem  = r_neg_rem ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div0     <= 1'b0;
      r_dividend <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_FIX) && !flush;
      if (w_accept) begin
        r_is_div   <= w_is_div;
        r_neg_res  <= w_signed && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
        r_neg_rem  <= w_signed && rs_val[XLEN-1];
        r_div0     <= (rt_val == '0);
        r_dividend <= rs_val;
      end
      if ((r_state == ST_IDLE) && op_valid && !flush) begin
        if (funct == FUNCT_MTHI) r_hi <= rs_val;
        if (funct == FUNCT_MTLO) r_lo <= rs_val;
      end else if ((r_state == ST_FIX) && !flush) begin
        if (!r_is_div) begin
          r_hi <= w_prod[2*XLEN-1:XLEN];
          r_lo <= w_prod[XLEN-1:0];
        end else if (r_div0) begin
          r_hi <= r_dividend;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem;
          r_lo <= w_quot;
        end
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed scenarios plus randomized
// mul/div traffic against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk, rst_n, op_valid, flush;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit guarantees no mul/div/MTxx issue while busy; the bench must honour that.
  always @(posedge clk) begin
    if (rst_n && busy && op_valid && !flush &&
        (funct inside {F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU})) begin
      errors++;
      $error("FAIL illegal_issue_while_busy funct=%h", funct);
    end
  end

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f)
      F_MULT:  return 64'(sa * sb);
      F_MULTU: return ua * ub;
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op_valid = 1'b1; funct = f; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0; funct = 6'h00;
  endtask

  // Issues a mul/div and waits (bounded) for done; reports latency and busy cycles.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc);
    issue(f, a, b);
    lat = 0; bc = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_mult_signed;
    int lat, bc;
    do_op(F_MULT, 32'hFFFF_FFFD, 32'd7, lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got=%0d exp=33", lat); end
    checks++; if (bc !== 33)  begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=33", bc); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo got=%h exp=FFFFFFEB", lo); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_single_pulse got=%b exp=0", done); end
    exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFEB;
  endtask

  task automatic test_multu;
    int lat, bc;
    do_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=FFFFFFFE", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
  endtask

  task automatic test_div;
    int lat, bc;
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got=%h exp=FFFFFFFD", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got=%h exp=FFFFFFFF", hi); end
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", lo); end
    checks++; if (hi !== 32'h0)         begin errors++; $display("FAIL div_ovf_hi got=%h exp=0", hi); end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    do_op(F_DIVU, 32'd100, 32'd0, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_lo got=%h exp=FFFFFFFF", lo); end
    checks++; if (hi !== 32'h0000_0064) begin errors++; $display("FAIL divu0_hi got=%h exp=00000064", hi); end
    do_op(F_DIV, 32'hFFFF_FF00, 32'd0, lat, bc);
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo got=%h exp=FFFFFFFF", lo); end
    checks++; if (hi !== 32'hFFFF_FF00) begin errors++; $display("FAIL div0_hi got=%h exp=FFFFFF00", hi); end
    exp_hi = 32'hFFFF_FF00; exp_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_mthi_flush;
    int dcnt;
    issue(F_MTHI, 32'h1234_5678, 32'h0);
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
    exp_hi = 32'h1234_5678;
    issue(F_MTLO, 32'hCAFE_F00D, 32'h0);
    checks++; if (lo !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_lo got=%h exp=CAFEF00D", lo); end
    exp_lo = 32'hCAFE_F00D;
    issue(F_MULTU, 32'd5, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    dcnt = 0;
    repeat (40) begin if (done) dcnt++; @(posedge clk); #1; end
    checks++; if (dcnt !== 0)   begin errors++; $display("FAIL flush_no_done got=%0d exp=0", dcnt); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL flush_hi got=%h exp=%h", hi, exp_hi); end
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL flush_lo got=%h exp=%h", lo, exp_lo); end
    // flush in IDLE blocks acceptance
    @(negedge clk); flush = 1'b1; op_valid = 1'b1; funct = F_MTHI; rs_val = 32'hDEAD_BEEF;
    @(posedge clk); #1; flush = 1'b0; op_valid = 1'b0; funct = 6'h00;
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL idle_flush_hi got=%h exp=%h", hi, exp_hi); end
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    issue(F_DIVU, 32'hFFFF_0000, 32'd3);
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL async_rst_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL async_rst_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(F_MULT, 32'd2, 32'd3, lat, bc);
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL post_rst_lo got=%h exp=6", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL post_rst_hi got=%h exp=0", hi); end
    exp_hi = 32'd0; exp_lo = 32'd6;
  endtask

  task automatic test_random;
    int lat, bc;
    logic [5:0] f;
    logic [31:0] a, b;
    logic [63:0] m;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      m = model(f, a, b);
      do_op(f, a, b, lat, bc);
      checks++;
      if (lat !== 33 || hi !== m[63:32] || lo !== m[31:0]) begin
        errors++;
        $display("FAIL random[%0d] f=%h a=%h b=%h got hi=%h lo=%h lat=%0d exp hi=%h lo=%h lat=33",
                 i, f, a, b, hi, lo, lat, m[63:32], m[31:0]);
      end
    end
  endtask

  // Next op issued in the same cycle the previous done is visible.
  task automatic test_back_to_back;
    int lat, bc;
    logic [63:0] m;
    do_op(F_DIVU, 32'd1000, 32'd7, lat, bc);
    m = model(F_DIVU, 32'd1000, 32'd7);
    checks++; if ({hi, lo} !== m) begin errors++; $display("FAIL b2b_first got=%h%h exp=%h", hi, lo, m); end
    do_op(F_MULT, 32'hFFFF_FFFF, 32'h8000_0000, lat, bc);
    m = model(F_MULT, 32'hFFFF_FFFF, 32'h8000_0000);
    checks++; if ({hi, lo} !== m || lat !== 33) begin errors++; $display("FAIL b2b_second got=%h%h lat=%0d exp=%h lat=33", hi, lo, lat, m); end
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; flush = 1'b0; funct = 6'h00;
    rs_val = '0; rt_val = '0; exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_mult_signed;
    test_multu;
    test_div;
    test_div_zero;
    test_mthi_flush;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
